// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-frame handshake between uart_rx_param and its consumer
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        input  rx_ready,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output rx_data,
        output rx_valid,
        output frame_err
    );

    modport slave (
        output rx_ready,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  rx_data,
        input  rx_valid,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with one-deep output register and overrun pulse
// Optional parity check (PARITY state, parity_err, PARITY_ODD) enabled by macro UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    input  logic            sample_tick,
    output logic            overrun,
    output logic            busy,
    uart_rx_param_if.master rx_if
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 rx_meta_q, rx_s_q;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 full_tick;
    logic                 complete;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
    logic                 perr_calc;

    assign perr_calc = (^shift_q) ^ par_bit_q ^ (PARITY_ODD != 0);
`endif

    assign full_tick = sample_tick && (tick_cnt_q == FULL_LAST);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        stop_err_d = stop_err_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = ferr_q;
        overrun_d  = 1'b0;
        complete   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
`endif
        if (state_q != S_IDLE && sample_tick) begin
            tick_cnt_d = tick_cnt_q + CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    stop_err_d = 1'b0;
                end
            end
            S_START: begin
                // Half a bit into the start bit: still low means a real frame.
                if (sample_tick && tick_cnt_q == HALF_LAST) begin
                    state_d    = rx_s_q ? S_IDLE : S_DATA;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                end
            end
            S_DATA: begin
                if (full_tick) begin
                    shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    tick_cnt_d = '0;
                    bit_idx_d  = bit_idx_q + 4'd1;
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (full_tick) begin
                    par_bit_d  = rx_s_q;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (full_tick) begin
                    stop_err_d = stop_err_q | ~rx_s_q;
                    tick_cnt_d = '0;
                    bit_idx_d  = bit_idx_q + 4'd1;
                    if (bit_idx_q == STOP_LAST) begin
                        complete  = 1'b1;
                        bit_idx_d = '0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
                bit_idx_d  = '0;
            end
        endcase

        // A finished frame may replace the held one only if it is free or being taken this edge.
        if (complete) begin
            if (!valid_q || rx_if.rx_ready) begin
                data_d  = shift_q;
                ferr_d  = stop_err_q | ~rx_s_q;
                valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                perr_d  = perr_calc;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_if.rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            shift_q    <= '0;
            stop_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            shift_q    <= shift_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = perr_q;
`endif
    assign overrun = overrun_q;
    assign busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed scoreboard bench for uart_rx_param (8N1 default and 7-bit/2-stop instances)
// Build with UART_RX_PARITY_EN defined to add the parity frames and parity_err checks.
module tb_uart_rx_param;
    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic tick_q = 1'b0;
    logic rx0    = 1'b1;
    logic rx1    = 1'b1;
    logic overrun0, busy0, overrun1, busy1;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   vlen = 0, last_vlen = 0, vcount = 0, ovr_cycles = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) tick_q <= ~tick_q;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(7)) if1 ();

    uart_rx_param dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .sample_tick(tick_q),
        .overrun(overrun0), .busy(busy0), .rx_if(if0)
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .sample_tick(tick_q),
        .overrun(overrun1), .busy(busy1), .rx_if(if1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (!tick_q) @(negedge clk);
        end
    endtask

    task automatic set_ready0(input logic v);
        @(posedge clk);
        #1 if0.rx_ready = v;
    endtask

    // Low stop bits end early so the receiver's mid-stop re-arm sees a false start, not a frame.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int nstop, input logic [1:0] stop_low, input logic par_flip);
        logic p;
        p = 1'b0;
        set_rx(sel, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < nbits; i++) begin
            set_rx(sel, data[i]);
            p = p ^ data[i];
            wait_ticks(OS);
        end
`ifdef UART_RX_PARITY_EN
        set_rx(sel, p ^ par_flip);
        wait_ticks(OS);
`endif
        for (int s = 0; s < nstop; s++) begin
            if (stop_low[s]) begin
                set_rx(sel, 1'b0);
                wait_ticks(OS - 4);
                set_rx(sel, 1'b1);
                wait_ticks(4);
            end else begin
                set_rx(sel, 1'b1);
                wait_ticks(OS);
            end
        end
        set_rx(sel, 1'b1);
        wait_ticks(OS / 2);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            vlen       = 0;
            prev_valid = 1'b0;
        end else begin
            if (if0.rx_valid) vlen++;
            else if (vlen != 0) begin
                last_vlen = vlen;
                vlen      = 0;
            end
            if (if0.rx_valid && !prev_valid) vcount++;
            prev_valid = if0.rx_valid;
            if (overrun0) ovr_cycles++;
            if (if0.rx_valid && if0.rx_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_frame: observed data=%0h expected no frame", if0.rx_data);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("sb_data", 32'(if0.rx_data), 32'(mon_e.data));
                    check("sb_frame_err", 32'(if0.frame_err), 32'(mon_e.ferr));
`ifdef UART_RX_PARITY_EN
                    check("sb_parity_err", 32'(if0.parity_err), 32'(mon_e.perr));
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        if0.rx_ready = 1'b0;
        if1.rx_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(if0.rx_valid), 32'd0);
        check("rst_data", 32'(if0.rx_data), 32'd0);
        check("rst_frame_err", 32'(if0.frame_err), 32'd0);
        check("rst_overrun", 32'(overrun0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ticks(20);

        set_ready0(1'b1);
        exp_q.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(0, 9'h0A5, 8, 1, 2'b00, 1'b0);
        wait_drain();
        check("a5_pulse_len", 32'(last_vlen), 32'd1);
        check("a5_valid_count", 32'(vcount), 32'd1);

        exp_q.push_back('{8'h3C, 1'b1, 1'b0});
        send_frame(0, 9'h03C, 8, 1, 2'b01, 1'b0);
        wait_drain();
        wait_ticks(OS);
        check("stop_low_idle_busy", 32'(busy0), 32'd0);

        nv = vcount;
        set_rx(0, 1'b0);
        wait_ticks(3);
        set_rx(0, 1'b1);
        wait_ticks(1);
        check("false_start_busy", 32'(busy0), 32'd1);
        wait_ticks(12);
        check("false_start_idle", 32'(busy0), 32'd0);
        check("false_start_no_frame", 32'(vcount), 32'(nv));

        set_ready0(1'b0);
        nv = vcount;
        send_frame(0, 9'h011, 8, 1, 2'b00, 1'b0);
        check("ovr_first_valid", 32'(if0.rx_valid), 32'd1);
        check("ovr_first_data", 32'(if0.rx_data), 32'h11);
        ovr_cycles = 0;
        send_frame(0, 9'h022, 8, 1, 2'b00, 1'b0);
        check("ovr_pulse_cycles", 32'(ovr_cycles), 32'd1);
        check("ovr_data_held", 32'(if0.rx_data), 32'h11);
        check("ovr_valid_held", 32'(if0.rx_valid), 32'd1);
        check("ovr_valid_count", 32'(vcount), 32'(nv + 1));
        exp_q.push_back('{8'h11, 1'b0, 1'b0});
        set_ready0(1'b1);
        repeat (3) @(negedge clk);
        check("ovr_consumed_valid", 32'(if0.rx_valid), 32'd0);
        check("ovr_consumed_q", 32'(exp_q.size()), 32'd0);

        nv = vcount;
        set_rx(0, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            set_rx(0, 1'b1);
            wait_ticks(OS);
        end
        wait_ticks(OS / 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_valid", 32'(if0.rx_valid), 32'd0);
        check("midrst_data", 32'(if0.rx_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ticks(20);
        check("midrst_idle", 32'(busy0), 32'd0);
        exp_q.push_back('{8'h3C, 1'b0, 1'b0});
        send_frame(0, 9'h03C, 8, 1, 2'b00, 1'b0);
        wait_drain();
        check("midrst_one_frame", 32'(vcount), 32'(nv + 1));

`ifdef UART_RX_PARITY_EN
        exp_q.push_back('{8'h07, 1'b0, 1'b1});
        send_frame(0, 9'h007, 8, 1, 2'b00, 1'b1);
        wait_drain();
        exp_q.push_back('{8'h07, 1'b0, 1'b0});
        send_frame(0, 9'h007, 8, 1, 2'b00, 1'b0);
        wait_drain();
`endif

        send_frame(1, 9'h055, 7, 2, 2'b10, 1'b0);
        check("d1_valid", 32'(if1.rx_valid), 32'd1);
        check("d1_data", 32'(if1.rx_data), 32'h55);
        check("d1_frame_err", 32'(if1.frame_err), 32'd1);
        @(posedge clk);
        #1 if1.rx_ready = 1'b1;
        @(posedge clk);
        #1 if1.rx_ready = 1'b0;
        @(negedge clk);
        check("d1_consumed", 32'(if1.rx_valid), 32'd0);
        wait_ticks(OS);
        send_frame(1, 9'h02A, 7, 2, 2'b00, 1'b0);
        check("d1_good_valid", 32'(if1.rx_valid), 32'd1);
        check("d1_good_data", 32'(if1.rx_data), 32'h2A);
        check("d1_good_frame_err", 32'(if1.frame_err), 32'd0);
        check("d1_busy_idle", 32'(busy1), 32'd0);
        check("d1_no_overrun", 32'(overrun1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
